// File: rtl/px_source_arbiter.sv
// Frame-granular arbiter sharing one gray/Sobel core between the SPI (0) and LFSR (1) pixel sources.
// Define ARB_FIXED_PRIORITY_EN to make requester 0 always win contention; default is round-robin.
module px_source_arbiter #(
   parameter int unsigned MAX_PIXEL_BITS = 8,
   parameter int unsigned FRAME_PIXELS   = 1024
) (
   input  logic                      clk_i,
   input  logic                      nreset_i,
   input  logic [1:0]                req_i,
   input  logic [1:0]                px_rdy_i,
   input  logic [MAX_PIXEL_BITS-1:0] px0_i,
   input  logic [MAX_PIXEL_BITS-1:0] px1_i,
   output logic [1:0]                gnt_o,
   output logic                      start_o,
   output logic                      core_px_rdy_o,
   output logic [MAX_PIXEL_BITS-1:0] core_px_o,
   input  logic                      core_px_rdy_i,
   input  logic [MAX_PIXEL_BITS-1:0] core_px_i,
   output logic [1:0]                out_px_rdy_o,
   output logic [MAX_PIXEL_BITS-1:0] out_px_o,
   output logic                      frame_done_o,
   output logic                      drop_o
);

   localparam int unsigned CW = $clog2(FRAME_PIXELS + 1);
   localparam logic [CW-1:0] LAST_PIX = CW'(FRAME_PIXELS - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DRAIN} state_e;

   state_e                    state_q, state_d;
   logic [1:0]                gnt_q, gnt_d;
   logic                      start_q, start_d;
   logic                      core_px_rdy_q, core_px_rdy_d;
   logic [MAX_PIXEL_BITS-1:0] core_px_q, core_px_d;
   logic [1:0]                out_px_rdy_q, out_px_rdy_d;
   logic [MAX_PIXEL_BITS-1:0] out_px_q, out_px_d;
   logic                      frame_done_q, frame_done_d;
   logic                      drop_q, drop_d;
   logic [CW-1:0]             pix_cnt_q, pix_cnt_d;
   logic [CW-1:0]             out_cnt_q, out_cnt_d;

   logic [1:0]                acc_mask_c;
   logic                      acc_c;
   logic                      ret_c;
   logic                      rel_c;
   logic                      drop_c;
   logic                      pick_one_c;
   logic [CW-1:0]             out_cnt_nxt_c;
   logic [MAX_PIXEL_BITS-1:0] own_px_c;

   // Only the owner's pixels are accepted, and only while streaming.
   assign acc_mask_c = (state_q == ST_STREAM) ? gnt_q : 2'b00;
   assign acc_c      = |(px_rdy_i & acc_mask_c);
   assign ret_c      = core_px_rdy_i && (state_q != ST_IDLE) && (out_cnt_q != '0);
   assign drop_c     = (|(px_rdy_i & ~acc_mask_c)) | (core_px_rdy_i & ~ret_c);
   assign own_px_c   = gnt_q[1] ? px1_i : px0_i;

   always_comb begin
      out_cnt_nxt_c = out_cnt_q;
      case ({acc_c, ret_c})
         2'b10:   out_cnt_nxt_c = out_cnt_q + CW'(1);
         2'b01:   out_cnt_nxt_c = out_cnt_q - CW'(1);
         default: out_cnt_nxt_c = out_cnt_q;
      endcase
   end

   // Release as the last outstanding result is registered, so done aligns with its out pulse.
   assign rel_c = (state_q == ST_DRAIN) && (out_cnt_nxt_c == '0);

`ifdef ARB_FIXED_PRIORITY_EN
   assign pick_one_c = req_i[1] & ~req_i[0];
`else
   logic rr_q, rr_d;

   // rr_q = 1 means requester 1 is preferred on the next contention.
   assign pick_one_c = req_i[1] & (~req_i[0] | rr_q);

   always_comb begin
      rr_d = rr_q;
      if (rel_c) rr_d = gnt_q[0];
   end

   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) rr_q <= 1'b0;
      else           rr_q <= rr_d;
   end
`endif

   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         state_q       <= ST_IDLE;
         gnt_q         <= 2'b00;
         start_q       <= 1'b0;
         core_px_rdy_q <= 1'b0;
         core_px_q     <= '0;
         out_px_rdy_q  <= 2'b00;
         out_px_q      <= '0;
         frame_done_q  <= 1'b0;
         drop_q        <= 1'b0;
         pix_cnt_q     <= '0;
         out_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         gnt_q         <= gnt_d;
         start_q       <= start_d;
         core_px_rdy_q <= core_px_rdy_d;
         core_px_q     <= core_px_d;
         out_px_rdy_q  <= out_px_rdy_d;
         out_px_q      <= out_px_d;
         frame_done_q  <= frame_done_d;
         drop_q        <= drop_d;
         pix_cnt_q     <= pix_cnt_d;
         out_cnt_q     <= out_cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (|req_i) state_d = ST_STREAM;
         ST_STREAM: if (acc_c && (pix_cnt_q == LAST_PIX)) state_d = ST_DRAIN;
         ST_DRAIN:  if (rel_c) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      gnt_d         = gnt_q;
      start_d       = 1'b0;
      core_px_rdy_d = acc_c;
      core_px_d     = core_px_q;
      out_px_rdy_d  = ret_c ? gnt_q : 2'b00;
      out_px_d      = core_px_rdy_i ? core_px_i : out_px_q;
      frame_done_d  = rel_c;
      drop_d        = drop_c;
      pix_cnt_d     = pix_cnt_q;
      out_cnt_d     = out_cnt_nxt_c;
      if (acc_c) begin
         core_px_d = own_px_c;
         pix_cnt_d = pix_cnt_q + CW'(1);
      end
      case (state_q)
         ST_IDLE: begin
            pix_cnt_d = '0;
            out_cnt_d = '0;
            if (|req_i) begin
               gnt_d   = pick_one_c ? 2'b10 : 2'b01;
               start_d = 1'b1;
            end
         end
         ST_DRAIN: if (rel_c) gnt_d = 2'b00;
         default: ;
      endcase
   end

   assign gnt_o         = gnt_q;
   assign start_o       = start_q;
   assign core_px_rdy_o = core_px_rdy_q;
   assign core_px_o     = core_px_q;
   assign out_px_rdy_o  = out_px_rdy_q;
   assign out_px_o      = out_px_q;
   assign frame_done_o  = frame_done_q;
   assign drop_o        = drop_q;

endmodule

// File: tb/tb_px_source_arbiter.sv
// Directed bench for px_source_arbiter with a 4-pixel frame; honours ARB_FIXED_PRIORITY_EN.
module tb_px_source_arbiter;

   logic       clk;
   logic       nreset;
   logic [1:0] req;
   logic [1:0] px_rdy;
   logic [7:0] px0;
   logic [7:0] px1;
   logic [1:0] gnt;
   logic       start;
   logic       core_rdy_o;
   logic [7:0] core_px_o;
   logic       core_rdy_i;
   logic [7:0] core_px_i;
   logic [1:0] out_rdy;
   logic [7:0] out_px;
   logic       frame_done;
   logic       drop;

   int ntests = 0;
   int nfail  = 0;

   px_source_arbiter #(.MAX_PIXEL_BITS(8), .FRAME_PIXELS(4)) dut (
      .clk_i         (clk),
      .nreset_i      (nreset),
      .req_i         (req),
      .px_rdy_i      (px_rdy),
      .px0_i         (px0),
      .px1_i         (px1),
      .gnt_o         (gnt),
      .start_o       (start),
      .core_px_rdy_o (core_rdy_o),
      .core_px_o     (core_px_o),
      .core_px_rdy_i (core_rdy_i),
      .core_px_i     (core_px_i),
      .out_px_rdy_o  (out_rdy),
      .out_px_o      (out_px),
      .frame_done_o  (frame_done),
      .drop_o        (drop)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [1:0] r, input logic [1:0] pr, input logic [7:0] p0,
                        input logic [7:0] p1, input logic cr, input logic [7:0] cp);
      req        = r;
      px_rdy     = pr;
      px0        = p0;
      px1        = p1;
      core_rdy_i = cr;
      core_px_i  = cp;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_gnt"},   32'(gnt), 32'h0);
      chk({tag, "_start"}, 32'(start), 32'h0);
      chk({tag, "_crdy"},  32'(core_rdy_o), 32'h0);
      chk({tag, "_cpx"},   32'(core_px_o), 32'h0);
      chk({tag, "_ordy"},  32'(out_rdy), 32'h0);
      chk({tag, "_opx"},   32'(out_px), 32'h0);
      chk({tag, "_done"},  32'(frame_done), 32'h0);
      chk({tag, "_drop"},  32'(drop), 32'h0);
   endtask

   // One contended frame: both requesters stream every cycle, the core returns 4 results.
   task automatic do_frame(input logic [1:0] exp_gnt);
      logic [7:0] base;
      base = (exp_gnt == 2'b01) ? 8'hA0 : 8'hB0;
      drive(2'b11, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00);
      tick();
      chk("cont_gnt", 32'(gnt), 32'(exp_gnt));
      chk("cont_start", 32'(start), 32'h1);
      for (int i = 0; i < 4; i++) begin
         drive(2'b11, 2'b11, 8'hA0 + 8'(i), 8'hB0 + 8'(i), 1'b0, 8'h00);
         tick();
         chk("cont_crdy", 32'(core_rdy_o), 32'h1);
         chk("cont_cpx", 32'(core_px_o), 32'(base + 8'(i)));
         chk("cont_drop", 32'(drop), 32'h1);
      end
      for (int j = 0; j < 4; j++) begin
         drive(2'b11, 2'b00, 8'h00, 8'h00, 1'b1, 8'hC0 + 8'(j));
         tick();
         chk("cont_ordy", 32'(out_rdy), 32'(exp_gnt));
         chk("cont_done", 32'(frame_done), (j == 3) ? 32'h1 : 32'h0);
      end
      chk("cont_gnt_rel", 32'(gnt), 32'h0);
   endtask

   initial begin
      nreset = 1'b0;
      drive(2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00);
      #12;
      chk_all_zero("reset");
      @(posedge clk);
      #1 nreset = 1'b1;

      // Single requester frame with one non-granted pulse and one overlapped return
      drive(2'b01, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00);
      tick();
      chk("s1_gnt", 32'(gnt), 32'h1);
      chk("s1_start", 32'(start), 32'h1);
      drive(2'b00, 2'b01, 8'h10, 8'h00, 1'b0, 8'h00);
      tick();
      chk("s2_start", 32'(start), 32'h0);
      chk("s2_crdy", 32'(core_rdy_o), 32'h1);
      chk("s2_cpx", 32'(core_px_o), 32'h10);
      drive(2'b00, 2'b11, 8'h11, 8'hAA, 1'b0, 8'h00);
      tick();
      chk("s3_cpx", 32'(core_px_o), 32'h11);
      chk("s3_drop", 32'(drop), 32'h1);
      drive(2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00);
      tick();
      chk("s4_crdy", 32'(core_rdy_o), 32'h0);
      chk("s4_drop", 32'(drop), 32'h0);
      drive(2'b00, 2'b01, 8'h12, 8'h00, 1'b1, 8'h90);
      tick();
      chk("s5_cpx", 32'(core_px_o), 32'h12);
      chk("s5_ordy", 32'(out_rdy), 32'h1);
      chk("s5_opx", 32'(out_px), 32'h90);
      drive(2'b00, 2'b01, 8'h13, 8'h00, 1'b1, 8'h91);
      tick();
      chk("s6_crdy", 32'(core_rdy_o), 32'h1);
      chk("s6_cpx", 32'(core_px_o), 32'h13);
      chk("s6_ordy", 32'(out_rdy), 32'h1);
      drive(2'b00, 2'b01, 8'h14, 8'h00, 1'b0, 8'h00);
      tick();
      chk("drain_crdy", 32'(core_rdy_o), 32'h0);
      chk("drain_drop", 32'(drop), 32'h1);
      chk("drain_gnt", 32'(gnt), 32'h1);
      drive(2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 8'h92);
      tick();
      chk("s8_opx", 32'(out_px), 32'h92);
      chk("s8_done", 32'(frame_done), 32'h0);
      chk("s8_gnt", 32'(gnt), 32'h1);
      drive(2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 8'h93);
      tick();
      chk("s9_ordy", 32'(out_rdy), 32'h1);
      chk("s9_done", 32'(frame_done), 32'h1);
      chk("s9_gnt", 32'(gnt), 32'h0);
      drive(2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00);
      tick();
      chk("s10_done", 32'(frame_done), 32'h0);
      chk("s10_start", 32'(start), 32'h0);

      // Spurious core output in IDLE
      drive(2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 8'h55);
      tick();
      chk("spur_drop", 32'(drop), 32'h1);
      chk("spur_ordy", 32'(out_rdy), 32'h0);
      drive(2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00);
      tick();
      chk("spur_drop_clr", 32'(drop), 32'h0);

      // Reset after two pixels of a requester 1 frame
      drive(2'b10, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00);
      tick();
      chk("r1_gnt", 32'(gnt), 32'h2);
      drive(2'b00, 2'b10, 8'h00, 8'h20, 1'b0, 8'h00);
      tick();
      chk("r1_cpx0", 32'(core_px_o), 32'h20);
      drive(2'b00, 2'b10, 8'h00, 8'h21, 1'b0, 8'h00);
      tick();
      chk("r1_cpx1", 32'(core_px_o), 32'h21);
      drive(2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00);
      #2 nreset = 1'b0;
      #1;
      chk_all_zero("rst_async");
      tick();
      chk_all_zero("rst_hold");
      nreset = 1'b1;
      tick();
      chk_all_zero("rst_after");
      drive(2'b10, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00);
      tick();
      chk("r2_gnt", 32'(gnt), 32'h2);
      chk("r2_start", 32'(start), 32'h1);
      for (int i = 0; i < 4; i++) begin
         drive(2'b00, 2'b10, 8'h00, 8'h30 + 8'(i), 1'b0, 8'h00);
         tick();
         chk("r2_crdy", 32'(core_rdy_o), 32'h1);
         chk("r2_cpx", 32'(core_px_o), 32'(8'h30 + 8'(i)));
      end
      for (int j = 0; j < 4; j++) begin
         drive(2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 8'h40 + 8'(j));
         tick();
         chk("r2_ordy", 32'(out_rdy), 32'h2);
         chk("r2_done", 32'(frame_done), (j == 3) ? 32'h1 : 32'h0);
         chk("r2_gnt_hold", 32'(gnt), (j == 3) ? 32'h0 : 32'h2);
      end

      // Contention held over three back-to-back frames
      do_frame(2'b01);
`ifdef ARB_FIXED_PRIORITY_EN
      do_frame(2'b01);
`else
      do_frame(2'b10);
`endif
      do_frame(2'b01);

      drive(2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00);
      tick();
      tick();
      chk("end_gnt", 32'(gnt), 32'h0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
